// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// | Module   : multicycle_control_unit                                      |
// | Purpose  : Main control FSM for the multi-cycle MIPS datapath.          |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_control_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          w_waiting;

  // The PC-load decision on zero is made in the datapath from pc_write_cond.
  logic w_unused_zero;
  assign w_unused_zero = zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = '0;
    w_waiting     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = 3'b100;
    illegal_op    = 1'b0;
    mem_timeout   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          pc_write = 1'b1;
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          w_waiting = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        op_d      = opcode;
        case (opcode)
          OP_R:          state_d = S_EXEC_R;
          OP_ADDI,
          OP_ORI:        state_d = S_EXEC_I;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
        else           w_waiting = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
        else           w_waiting = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b111;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (op_q == OP_ORI) ? 3'b101 : 3'b100;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b110;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Stored count tops out at TIMEOUT_CYCLES-1; the limiting cycle aborts instead of counting.
    if (w_waiting) begin
      if (cnt_q == CNT_LIM) begin
        mem_timeout = 1'b1;
        state_d     = S_FETCH;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// | Module   : tb_multicycle_control_unit                                   |
// | Purpose  : Self-checking bench for the multi-cycle control FSM.         |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control_unit;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_timeout;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;

  multicycle_control_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    logic ill, mto;
  } exp_t;

  typedef struct {
    logic       rdy;
    logic [5:0] op;
    exp_t       e;
    int         id;
  } cyc_t;

  exp_t obs;
  assign obs = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                alu_op, illegal_op, mem_timeout};

  int   checks = 0;
  int   errors = 0;
  int   instr_id = 0;
  cyc_t q[$];

  localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, ORI = 6'b001101,
                         LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, J = 6'b000010;

  function automatic exp_t blank(input int s);
    exp_t e;
    e     = '0;
    e.st  = 4'(s);
    e.aop = 3'b100;
    return e;
  endfunction

  // rdy < 0 means the handshake is irrelevant in that cycle, so it is randomized.
  task automatic push(input exp_t e, input int rdy, input logic [5:0] op);
    cyc_t c;
    c.e   = e;
    c.rdy = (rdy < 0) ? 1'($urandom_range(0, 1)) : 1'(rdy);
    c.op  = op;
    c.id  = instr_id;
    q.push_back(c);
  endtask

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  // A memory phase with w not-ready cycles: completes if w < TO, else aborts on the TO-th wait.
  task automatic mem_phase(input exp_t base, input int w, output bit ok);
    exp_t e;
    int   n;
    ok = (w < TO);
    n  = ok ? w : TO;
    for (int i = 0; i < n; i++) begin
      e = base;
      if (!ok && i == TO - 1) e.mto = 1'b1;
      push(e, 0, junk());
    end
    if (ok) begin
      e = base;
      if (base.st == 4'd0) begin
        e.pcw = 1'b1;
        e.irw = 1'b1;
      end
      push(e, 1, junk());
    end
  endtask

  task automatic gen_instr(input logic [5:0] op, input int fw, input int mw);
    exp_t e;
    bit   ok;
    instr_id++;
    e = blank(0); e.mr = 1; e.asb = 2'b01;
    mem_phase(e, fw, ok);
    if (!ok) return;
    e = blank(1); e.asb = 2'b11;
    if (!(op inside {R, ADDI, ORI, LW, SW, BEQ, J})) begin
      e.ill = 1;
      push(e, -1, op);
      return;
    end
    push(e, -1, op);
    case (op)
      R: begin
        e = blank(6); e.asa = 1; e.aop = 3'b111; push(e, -1, junk());
        e = blank(7); e.rw = 1; e.rdst = 1;     push(e, -1, junk());
      end
      ADDI, ORI: begin
        e = blank(8); e.asa = 1; e.asb = 2'b10;
        e.aop = (op == ORI) ? 3'b101 : 3'b100;  push(e, -1, junk());
        e = blank(9); e.rw = 1;                 push(e, -1, junk());
      end
      LW, SW: begin
        e = blank(2); e.asa = 1; e.asb = 2'b10; push(e, -1, junk());
        if (op == LW) begin
          e = blank(3); e.mr = 1; e.iord = 1;
          mem_phase(e, mw, ok);
          if (ok) begin
            e = blank(4); e.rw = 1; e.m2r = 1; push(e, -1, junk());
          end
        end else begin
          e = blank(5); e.mw = 1; e.iord = 1;
          mem_phase(e, mw, ok);
        end
      end
      BEQ: begin
        e = blank(10); e.asa = 1; e.aop = 3'b110; e.pcwc = 1; e.pcs = 2'b01;
        push(e, -1, junk());
      end
      default: begin
        e = blank(11); e.pcw = 1; e.pcs = 2'b10; push(e, -1, junk());
      end
    endcase
  endtask

  task automatic run(input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      mem_ready = c.rdy;
      opcode    = c.op;
      zero      = 1'($urandom_range(0, 1));
      #1;
      checks++;
      assert (obs === c.e) else begin
        errors++;
        $error("FAIL instr%0d outputs: observed=%h expected=%h", c.id, obs, c.e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_all();
    run(q.size());
  endtask

  logic [5:0] legal [7];

  initial begin
    legal = '{R, ADDI, ORI, LW, SW, BEQ, J};
    reset = 1'b1; mem_ready = 1'b0; opcode = '0; zero = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    assert (state === 4'd0 && reg_write === 1'b0 && mem_write === 1'b0 &&
            illegal_op === 1'b0 && mem_timeout === 1'b0) else begin
      errors++;
      $error("FAIL reset_state: observed state=%0d rw=%b mw=%b expected state=0 rw=0 mw=0",
             state, reg_write, mem_write);
    end

    // Directed scenarios
    gen_instr(R, 0, 0);
    gen_instr(LW, 0, 3);
    gen_instr(ORI, 1, 0);
    gen_instr(ADDI, 0, 0);
    gen_instr(BEQ, 0, 0);
    gen_instr(J, 2, 0);
    gen_instr(6'b111111, 0, 0);
    gen_instr(SW, 0, TO);
    gen_instr(SW, 0, TO - 1);
    gen_instr(LW, 0, TO);
    gen_instr(SW, 0, 0);
    gen_instr(R, TO + 5, 0);
    gen_instr(R, 0, 0);
    run_all();

    // Reset in the middle of EXEC_R aborts the instruction
    gen_instr(R, 0, 0);
    run(2);
    reset = 1'b1; mem_ready = 1'b1; opcode = SW;
    #1;
    checks++;
    assert (state === 4'd6) else begin
      errors++;
      $error("FAIL pre_reset_exec_r: observed state=%0d expected 6", state);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    q.delete();
    #1;
    checks++;
    assert (state === 4'd0 && reg_write === 1'b0 && mem_write === 1'b0) else begin
      errors++;
      $error("FAIL reset_mid_exec: observed state=%0d rw=%b mw=%b expected state=0 rw=0 mw=0",
             state, reg_write, mem_write);
    end

    // Randomized instruction stream
    for (int k = 0; k < 60; k++) begin
      logic [5:0] op;
      int fw, mw;
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 1) ? 6'b111111 : 6'b001111);
      else                           op = legal[$urandom_range(0, 6)];
      fw = ($urandom_range(0, 15) == 0) ? TO + 2 : $urandom_range(0, 3);
      case ($urandom_range(0, 7))
        0:       mw = TO - 1;
        1:       mw = TO;
        default: mw = $urandom_range(0, 4);
      endcase
      gen_instr(op, fw, mw);
    end
    run_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory and write-back over several clocks, sharing one ALU and one unified memory port.
- Drives all datapath selects, enables and the 3-bit ALUOp consumed by the ALU control decoder.
- Stalls on a memory ready handshake; aborts a hung access after a bounded wait.

Parameters:
- TIMEOUT_CYCLES, 15, maximum wait cycles for mem_ready in any memory state before abort (legal range 1..255).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  6  instruction[31:26], sampled only in DECODE
- zero  input  1  ALU zero flag, sampled in BRANCH
- mem_ready  input  1  memory access complete this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified by zero
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  write-back data select: 0 = ALUOut, 1 = MDR
- reg_dst  output  1  destination select: 0 = rt, 1 = rd
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
- pc_source  output  2  PC mux select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_op  output  3  111 = R-type (funct decode), 100 = add, 101 = or, 110 = subtract
- illegal_op  output  1  one-cycle pulse on unsupported opcode
- mem_timeout  output  1  one-cycle pulse on memory abort
- state  output  4  current state encoding, for debug

Behaviour:
- Reset: state <= FETCH, wait counter <= 0, illegal_op = mem_timeout = 0. Reset mid-operation aborts the instruction with no further reg_write or mem_write.
- Moore outputs: every output is decoded from state only, except pc_write and ir_write, which are qualified by mem_ready in FETCH. Deasserted outputs default to 0; alu_op defaults to 100.
- Opcodes: R 000000, ADDI 001000, ORI 001101, LW 100011, SW 101011, BEQ 000100, J 000010.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10, JUMP=11.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=100, pc_source=00.
  - If mem_ready: pc_write=1, ir_write=1, go to DECODE. Otherwise stay.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=100 (branch target into ALUOut).
  - Next state: R->EXEC_R, ADDI->EXEC_I, ORI->EXEC_I, LW/SW->MEM_ADDR, BEQ->BRANCH, J->JUMP.
  - Any other opcode: pulse illegal_op, return to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=100. LW->MEM_READ, SW->MEM_WRITE. The opcode is held in an internal register latched in DECODE.
- MEM_READ: mem_read=1, i_or_d=1. On mem_ready go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. On mem_ready go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=111, then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=100 for ADDI or 101 for ORI, then I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=110, pc_write_cond=1, pc_source=01, then FETCH. The PC loads only if zero=1.
- JUMP: pc_write=1, pc_source=10, then FETCH.
- Cycles per instruction with zero-wait memory: LW 5; SW, R, ADDI, ORI 4; BEQ, J 3.
- Memory wait counter:
  - Increments each cycle in FETCH, MEM_READ or MEM_WRITE while mem_ready=0.
  - Clears on state exit.
  - When the counter reaches TIMEOUT_CYCLES with mem_ready still 0: pulse mem_timeout, go to FETCH with no pc_write, ir_write, reg_write or further mem_write.
  - mem_ready=1 in the same cycle as the counter hitting the limit counts as success.
- Counter width is ceil(log2(TIMEOUT_CYCLES+1)); it must not wrap.

Test Plan:
- Reset held 2 cycles mid-EXEC_R -> state=0, reg_write=0, mem_write=0 on the cycle after release; FETCH begins.
- R-type (opcode 000000), mem_ready always 1 -> states 0,1,6,7,0. alu_op=111 in EXEC_R; reg_write=1, reg_dst=1 only in R_WB.
- LW (100011), mem_ready low 3 cycles in MEM_READ -> states 0,1,2,3,3,3,3,4,0. mem_read and i_or_d held 1 throughout MEM_READ; reg_write with mem_to_reg=1 in MEM_WB.
- ORI (001101) -> alu_op=101 in EXEC_I. BEQ with zero=1 -> pc_write_cond=1, pc_source=01, alu_op=110. J -> pc_write=1, pc_source=10 in JUMP.
- Opcode 111111 in DECODE -> illegal_op pulses for exactly 1 cycle; next state FETCH; no reg_write.
- SW with mem_ready held 0, TIMEOUT_CYCLES=15 -> mem_timeout pulses after 15 wait cycles; return to FETCH. Repeat with mem_ready=1 on the 15th cycle -> no timeout, normal FETCH.
